// File: rtl/led_pattern_if.sv
// LED pattern I/O bundle: raw mode button in, five LED drives out.
// slave = the pattern block, master = whatever drives the button.
interface led_pattern_if;
  logic btn;
  logic LED0;
  logic LED1;
  logic LED2;
  logic LED3;
  logic LED4;

  modport master (
    output btn,
    input  LED0, LED1, LED2, LED3, LED4
  );

  modport slave (
    input  btn,
    output LED0, LED1, LED2, LED3, LED4
  );
endinterface

// File: rtl/led_pattern.sv
// Five-LED pattern generator: debounced button cycles through
// STATIC, COUNT, SCAN and BLINK; a prescaler paces the steps.
module led_pattern #(
  parameter int unsigned DIV = 3000000,
  parameter int unsigned DEB = 120000
) (
  input  logic    clk,
  input  logic    rstn,
  led_pattern_if.slave io
);

  typedef enum logic [1:0] {
    STATIC = 2'd0,
    COUNT  = 2'd1,
    SCAN   = 2'd2,
    BLINK  = 2'd3
  } mode_e;

  localparam logic [23:0] DIV_M1 = 24'(DIV - 1);
  localparam logic [19:0] DEB_M1 = 20'(DEB - 1);
  localparam logic [4:0]  STATIC_PAT = 5'b10111;

  logic        s1_q, s2_q;
  logic        lvl_q, lvl_d;
  logic [19:0] dcnt_q, dcnt_d;
  logic        press;
  logic [23:0] pre_q, pre_d;
  logic        tick;
  mode_e       mode_q, mode_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [2:0]  pos_q, pos_d;
  logic        dn_q, dn_d;
  logic        blink_q, blink_d;
  logic [4:0]  led_q, led_d;

  always_comb begin
    lvl_d  = lvl_q;
    dcnt_d = '0;
    press  = 1'b0;
    // level flips on the DEB-th consecutive differing sample
    if (s2_q != lvl_q) begin
      if (dcnt_q == DEB_M1) begin
        lvl_d = s2_q;
        press = s2_q;
      end else begin
        dcnt_d = dcnt_q + 20'd1;
      end
    end
  end

  assign tick  = (pre_q == DIV_M1);
  assign pre_d = (press || tick) ? 24'd0
                                 : pre_q + 24'd1;

  always_comb begin
    mode_d  = mode_q;
    cnt_d   = cnt_q;
    pos_d   = pos_q;
    dn_d    = dn_q;
    blink_d = blink_q;
    if (press) begin
      mode_d  = mode_e'(mode_q + 2'd1);
      cnt_d   = '0;
      pos_d   = '0;
      dn_d    = 1'b0;
      blink_d = 1'b1;
    end else if (tick) begin
      unique case (mode_q)
        COUNT: cnt_d = cnt_q + 5'd1;
        SCAN: begin
          if (!dn_q) begin
            if (pos_q == 3'd4) begin
              pos_d = 3'd3;
              dn_d  = 1'b1;
            end else begin
              pos_d = pos_q + 3'd1;
            end
          end else if (pos_q == 3'd0) begin
            pos_d = 3'd1;
            dn_d  = 1'b0;
          end else begin
            pos_d = pos_q - 3'd1;
          end
        end
        BLINK:   blink_d = ~blink_q;
        default: ;
      endcase
    end
  end

  always_comb begin
    led_d = STATIC_PAT;
    unique case (mode_d)
      STATIC:  led_d = STATIC_PAT;
      COUNT:   led_d = cnt_d;
      SCAN:    led_d = 5'd1 << pos_d;
      BLINK:   led_d = {5{blink_d}};
      default: led_d = STATIC_PAT;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      s1_q    <= 1'b0;
      s2_q    <= 1'b0;
      lvl_q   <= 1'b0;
      dcnt_q  <= '0;
      pre_q   <= '0;
      mode_q  <= STATIC;
      cnt_q   <= '0;
      pos_q   <= '0;
      dn_q    <= 1'b0;
      blink_q <= 1'b1;
      led_q   <= STATIC_PAT;
    end else begin
      s1_q    <= io.btn;
      s2_q    <= s1_q;
      lvl_q   <= lvl_d;
      dcnt_q  <= dcnt_d;
      pre_q   <= pre_d;
      mode_q  <= mode_d;
      cnt_q   <= cnt_d;
      pos_q   <= pos_d;
      dn_q    <= dn_d;
      blink_q <= blink_d;
      led_q   <= led_d;
    end
  end

  assign io.LED0 = led_q[0];
  assign io.LED1 = led_q[1];
  assign io.LED2 = led_q[2];
  assign io.LED3 = led_q[3];
  assign io.LED4 = led_q[4];

endmodule

// File: tb/tb_led_pattern.sv
// Bench for led_pattern: random button traffic against a
// step-count reference model, checked through a scoreboard queue.
module tb_led_pattern;
  localparam int DIV = 4;
  localparam int DEB = 2;
  localparam logic [4:0] STAT = 5'b10111;

  logic clk  = 1'b0;
  logic rstn = 1'b1;

  led_pattern_if io();

  led_pattern #(.DIV(DIV), .DEB(DEB)) dut (
    .clk  (clk),
    .rstn (rstn),
    .io   (io)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  logic [4:0] exp_q[$];
  logic [4:0] mon_e;
  logic [4:0] mon_g;

  // model: mode, steps since mode entry, prescaler phase,
  // debounce level/run length, two-deep input history
  int m_mode, m_n, m_phase, m_lvl, m_run, m_h0, m_h1;
  int m_coinc = 0;

  function automatic logic [4:0] leds();
    return {io.LED4, io.LED3, io.LED2, io.LED1, io.LED0};
  endfunction

  function automatic logic [4:0] pattern(int mode, int n);
    int p;
    case (mode)
      1: return 5'(n % 32);
      2: begin
        p = n % 8;
        return 5'(1 << ((p <= 4) ? p : 8 - p));
      end
      3: return (n % 2 == 0) ? 5'b11111 : 5'b00000;
      default: return STAT;
    endcase
  endfunction

  function automatic void m_reset();
    m_mode = 0; m_n = 0; m_phase = 0;
    m_lvl = 0; m_run = 0; m_h0 = 0; m_h1 = 0;
  endfunction

  function automatic void m_step(int b);
    int sync;
    bit press;
    bit tick;
    sync  = m_h1;
    m_h1  = m_h0;
    m_h0  = b;
    press = 1'b0;
    if (sync != m_lvl) begin
      m_run++;
      if (m_run == DEB) begin
        m_lvl = sync;
        m_run = 0;
        press = (sync == 1);
      end
    end else begin
      m_run = 0;
    end
    tick = (m_phase == DIV - 1);
    if (press) begin
      if (tick) m_coinc++;
      m_mode  = (m_mode + 1) % 4;
      m_n     = 0;
      m_phase = 0;
    end else if (tick) begin
      m_n++;
      m_phase = 0;
    end else begin
      m_phase++;
    end
  endfunction

  always @(posedge clk) begin
    #1;
    cyc++;
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      mon_g = leds();
      checks++;
      if (mon_g !== mon_e) begin
        errors++;
        $display("FAIL leds cyc=%0d got=%b want=%b",
                 cyc, mon_g, mon_e);
      end
    end
  end

  task automatic step(input logic b);
    @(negedge clk);
    rstn   = 1'b1;
    io.btn = b;
    m_step(int'(b));
    exp_q.push_back(pattern(m_mode, m_n));
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0);
  endtask

  task automatic press_clean();
    repeat (DEB + 2 + $urandom_range(0, 3)) step(1'b1);
    repeat (DEB + 2 + $urandom_range(0, 3)) step(1'b0);
  endtask

  task automatic press_bounce();
    for (int i = 0; i < 10; i++) step(i % 2 == 0);
    repeat (DEB + 3) step(1'b1);
    repeat (DEB + 3) step(1'b0);
  endtask

  task automatic press_on_tick();
    int guard;
    idle(DEB + 3);
    guard = 0;
    while ((m_phase + DEB + 1) % DIV != DIV - 1
           && guard < 2 * DIV) begin
      step(1'b0);
      guard++;
    end
    repeat (DEB + 3) step(1'b1);
    repeat (DEB + 3) step(1'b0);
  endtask

  task automatic do_reset(input int n);
    @(negedge clk);
    rstn   = 1'b0;
    io.btn = 1'($urandom);
    #1;
    checks++;
    if (leds() !== STAT) begin
      errors++;
      $display("FAIL async_reset got=%b want=%b",
               leds(), STAT);
    end
    m_reset();
    exp_q.push_back(STAT);
    repeat (n - 1) begin
      @(negedge clk);
      exp_q.push_back(STAT);
    end
  endtask

  initial begin
    int op;
    io.btn = 1'b0;
    #2 rstn = 1'b0;
    #1;
    checks++;
    if (leds() !== STAT) begin
      errors++;
      $display("FAIL reset_state got=%b want=%b",
               leds(), STAT);
    end
    m_reset();
    repeat (2) begin
      @(negedge clk);
      exp_q.push_back(STAT);
    end

    idle(20);
    press_clean();
    idle(40 + 33 * DIV);
    press_clean();
    idle(44);
    press_bounce();
    idle(20);
    do_reset(2);
    repeat (3) press_clean();
    idle(12);
    press_clean();
    idle(12);
    repeat (4) begin
      press_on_tick();
      idle(6);
    end

    repeat (300) begin
      op = $urandom_range(0, 6);
      case (op)
        0: idle($urandom_range(1, 12));
        1: press_clean();
        2: press_bounce();
        3: begin
          step(1'b1);
          step(1'b0);
        end
        4: press_on_tick();
        5: do_reset($urandom_range(1, 3));
        default: repeat ($urandom_range(1, 6))
                   step(1'($urandom));
      endcase
    end
    idle(4);

    @(posedge clk);
    #3;
    if (m_coinc == 0)
      $display("note: no press landed on a tick");
    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule
